// File: rtl/multu_hilo_unit_pkg.sv
// Shared definitions for the extension-code consumers: control codes,
// multiply FSM states and counter sizing.
package multu_hilo_unit_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  // Extension control codes, shared with the extension decoder.
  localparam logic [3:0] EXT_NONE  = 4'b0000;
  localparam logic [3:0] EXT_MULTU = 4'b0010;
  localparam logic [3:0] EXT_MFLO  = 4'b0100;
  localparam logic [3:0] EXT_MFHI  = 4'b0101;
  localparam logic [3:0] EXT_JR    = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Iteration counter width for a given operand width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(MULT_WIDTH);

  // Codes that depend on the HI/LO unit and therefore must wait for it.
  function automatic logic uses_hilo(input logic [3:0] code);
    return (code == EXT_MULTU) || (code == EXT_MFLO) || (code == EXT_MFHI);
  endfunction

endpackage

// File: rtl/mul_iter_dp.sv
// Shift-add unsigned multiply datapath: one multiplier bit per step.
module mul_iter_dp
  import multu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;

  // One iteration: conditional add into the upper half (carry kept), then
  // shift the {carry, acc_hi, acc_lo} chain right by one.
  always_comb begin
    sum      = {1'b0, acc_hi_q} + ({1'b0, mcand_q} & {(WIDTH+1){acc_lo_q[0]}});
    acc_hi_d = sum[WIDTH:1];
    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
  end

  // The post-step value is exported so the final iteration commits directly.
  assign product = {acc_hi_d, acc_lo_d};

  // Accumulator and multiplicand registers: load on accept, advance while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
    end else if (load) begin
      acc_hi_q <= '0;
      acc_lo_q <= src_b;
      mcand_q  <= src_a;
    end else if (step) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Execute-stage HI/LO unit: iterative multu, mflo/mfhi reads, pipeline stall.
module multu_hilo_unit
  import multu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ext_cont,
  input  logic             valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic                accept;
  logic                last_iter;
  logic [2*WIDTH-1:0]  dp_product;

  assign busy      = (state_q == RUN);
  assign accept    = (state_q == IDLE) && valid && (ext_cont == EXT_MULTU);
  assign last_iter = busy && (count_q == CW'(WIDTH - 1));
  // A reset landing on the final iteration aborts it, so no pulse either.
  assign done      = last_iter && !reset;
  assign stall     = busy && valid && uses_hilo(ext_cont);

  mul_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    (busy),
    .src_a   (src_a),
    .src_b   (src_b),
    .product (dp_product)
  );

  // Next-state and iteration counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // FSM, counter and HI/LO registers; HI/LO commit on the last iteration edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (last_iter) begin
        hi_q <= dp_product[2*WIDTH-1:WIDTH];
        lo_q <= dp_product[WIDTH-1:0];
      end
    end
  end

  // Read mux: always from the committed registers, never the accumulator.
  always_comb begin
    hilo_out = '0;
    case (ext_cont)
      EXT_MFLO: hilo_out = lo_q;
      EXT_MFHI: hilo_out = hi_q;
      default:  hilo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed, table-driven bench for multu_hilo_unit.
module tb_multu_hilo_unit;
  import multu_hilo_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ext_cont;
  logic        valid;
  logic [31:0] src_a, src_b;
  logic [31:0] hilo_out;
  logic        busy, stall, done;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .ext_cont (ext_cont),
    .valid    (valid),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_out (hilo_out),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] ec, input logic v, input logic [31:0] a, input logic [31:0] b);
    ext_cont = ec;
    valid    = v;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(EXT_MFLO, 1'b1, '0, '0);
    check({tag, " mflo"}, hilo_out, exp_lo);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
    drive(EXT_MFHI, 1'b1, '0, '0);
    check({tag, " mfhi"}, hilo_out, exp_hi);
  endtask

  // Issue one multu, track the busy window and done pulse, then read HI/LO.
  task automatic run_multu(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    int nd;
    int done_at;
    drive(EXT_MULTU, 1'b1, a, b);
    check({tag, " accept stall"}, {31'd0, stall}, 32'd0);
    tick();
    // Scramble operands after acceptance; they must already be latched.
    drive(EXT_NONE, 1'b1, ~a, ~b);
    nb = 0; nd = 0; done_at = -1;
    while (busy && nb < 40) begin
      if (done) begin
        nd++;
        done_at = nb;
      end
      nb++;
      tick();
    end
    check({tag, " busy cycles"}, nb, 32'd32);
    check({tag, " done count"}, nd, 32'd1);
    check({tag, " done cycle"}, done_at, 32'd31);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int n;
    int bad;
    int nd;
    vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    vecs[3] = '{32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A};
    vecs[4] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{32'd0,          32'hDEAD_BEEF,  32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{32'h1234_5678,  32'h0000_0010,  32'h0000_0001, 32'h2345_6780};
    vecs[9] = '{32'h000F_4240,  32'h000F_4240,  32'h0000_00E8, 32'hD4A5_1000};

    reset = 1'b1;
    drive(EXT_NONE, 1'b0, '0, '0);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;

    // Reset state
    read_hilo("reset", 32'h0, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    // Table of products
    for (int i = 0; i < 10; i++)
      run_multu($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // valid=0 multu is ignored; reads still decode; unknown code reads 0
    drive(EXT_MULTU, 1'b0, 32'd9, 32'd9);
    tick();
    check("novalid busy", {31'd0, busy}, 32'd0);
    drive(EXT_MFLO, 1'b0, '0, '0);
    check("novalid mflo", hilo_out, 32'hD4A5_1000);
    drive(4'b0011, 1'b1, '0, '0);
    check("unknown code out", hilo_out, 32'h0);

    // mflo one cycle into a multu: stalled 31 cycles, old LO visible
    drive(EXT_MULTU, 1'b1, 32'h8000_0000, 32'd2);
    tick();
    drive(EXT_NONE, 1'b1, '0, '0);
    check("run0 busy", {31'd0, busy}, 32'd1);
    check("run0 stall", {31'd0, stall}, 32'd0);
    tick();
    drive(EXT_MFLO, 1'b1, '0, '0);
    n = 0; bad = 0;
    while (stall && n < 40) begin
      if (hilo_out !== 32'hD4A5_1000) bad++;
      n++;
      tick();
    end
    check("mflo stall cycles", n, 32'd31);
    check("mflo held old lo", bad, 32'd0);
    read_hilo("stallres", 32'h0000_0001, 32'h0000_0000);

    // Back-to-back multu: second held 32 cycles, accepted as busy drops
    drive(EXT_MULTU, 1'b1, 32'd7, 32'd6);
    tick();
    drive(EXT_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000);
    n = 0; nd = 0;
    while (stall && n < 40) begin
      if (done) nd++;
      n++;
      tick();
    end
    check("b2b stall cycles", n, 32'd32);
    check("b2b first done", nd, 32'd1);
    check("b2b idle busy", {31'd0, busy}, 32'd0);
    tick();
    drive(EXT_NONE, 1'b1, '0, '0);
    check("b2b second accepted", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("b2b second busy", n, 32'd32);
    read_hilo("b2b", 32'h0000_0001, 32'h0000_0000);

    // Set HI=1, LO=2, then abort a multu with reset at cycle 10
    run_multu("pre", 32'd2, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002);
    drive(EXT_MULTU, 1'b1, 32'd3, 32'd5);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(EXT_JR, 1'b1, '0, '0);
      tick();
    end
    drive(EXT_JR, 1'b1, '0, '0);
    check("jr busy", {31'd0, busy}, 32'd1);
    check("jr stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort done", {31'd0, done}, 32'd0);
    tick();
    reset = 1'b0;
    drive(EXT_NONE, 1'b1, '0, '0);
    check("abort busy", {31'd0, busy}, 32'd0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) nd++;
      tick();
    end
    check("abort no done", nd, 32'd0);
    read_hilo("abort", 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
